dcache_controller: RTL

Direct-mapped, write-through, no-write-allocate data-cache controller between the CPU memory stage and main memory. It owns a 256-entry array of `CacheBlock` entries: 1 valid bit, one 32-bit data word and a 22-bit tag per entry. The block resolves every load/store request as a hit or a miss and sequences main-memory reads (line fill) and writes (write-through). It stalls the pipeline while the request completes, and can invalidate the whole array on a flush.

---
 rtl/dcache_controller_if.sv | 35 +++
 rtl/dcache_controller.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dcache_controller_if.sv
// CPU-side request/stall signals and main-memory request/ack signals of the data cache.
// master = the cache controller, slave = the pipeline/memory environment around it.
interface dcache_controller_if #(
    parameter int DATA_WIDTH = 32
);
    // Handshakes: the CPU holds req_* stable while stall=1 and the request retires on
    // the first edge with stall=0; the cache holds mem_* stable while mem_req=1 and the
    // transfer completes on the edge where mem_ack=1 (mem_rdata valid in that cycle).
    logic                  req_valid;
    logic                  req_we;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [1:0]            req_size;
    logic                  flush;
    logic                  stall;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [1:0]            mem_size;
    logic [1:0]            mem_byte_off;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_size, flush, mem_ack, mem_rdata,
        output stall, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_size, mem_byte_off
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_size, flush, mem_ack, mem_rdata,
        input  stall, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_size, mem_byte_off
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with
// whole-array flush; dbg_state exposes the FSM state encoding.
module dcache_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int SET_SIZE   = 8
) (
    input  logic                clk,
    input  logic                rst,
    dcache_controller_if.master bus,
    output logic [2:0]          dbg_state
);
    localparam int SETS  = 1 << SET_SIZE;
    localparam int TAG_W = DATA_WIDTH - SET_SIZE - 2;
    localparam int LANES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, RD_MISS, WR_THRU, DONE, FLUSH} state_t;

    state_t                state, state_nx;
    logic [SETS-1:0]       valid;
    logic [TAG_W-1:0]      tag_mem  [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS];
    logic [SET_SIZE-1:0]   flush_cnt;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [TAG_W-1:0]      req_tag, fill_tag;
    logic [SET_SIZE-1:0]   req_idx, fill_idx;
    logic                  hit;
    logic [LANES-1:0]      byte_en;
    logic [DATA_WIDTH-1:0] lane_data, merged;
    logic                  start_rd, start_wr, store_hit, fill;

    assign req_tag   = bus.req_addr[DATA_WIDTH-1 -: TAG_W];
    assign req_idx   = bus.req_addr[SET_SIZE+1:2];
    assign fill_tag  = bus.mem_addr[DATA_WIDTH-1 -: TAG_W];
    assign fill_idx  = bus.mem_addr[SET_SIZE+1:2];
    assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign dbg_state = state;

    // Store data is replicated into every lane it could land in; byte_en picks the live ones.
    always_comb begin
        byte_en   = '0;
        lane_data = '0;
        for (int i = 0; i < LANES; i++) begin
            case (bus.req_size)
                2'b00: begin
                    byte_en[i]       = 1'b1;
                    lane_data[8*i+:8] = bus.req_wdata[8*i+:8];
                end
                2'b01: begin
                    byte_en[i]       = (i[1] == bus.req_addr[1]);
                    lane_data[8*i+:8] = bus.req_wdata[8*(i%2)+:8];
                end
                2'b10: begin
                    byte_en[i]       = (2'(i) == bus.req_addr[1:0]);
                    lane_data[8*i+:8] = bus.req_wdata[7:0];
                end
                default: begin
                    byte_en[i]       = 1'b0;
                    lane_data[8*i+:8] = 8'h00;
                end
            endcase
        end
        for (int i = 0; i < LANES; i++) begin
            merged[8*i+:8] = byte_en[i] ? lane_data[8*i+:8] : data_mem[req_idx][8*i+:8];
        end
    end

    always_comb begin
        state_nx  = state;
        bus.stall = 1'b0;
        bus.rdata = rdata_q;
        start_rd  = 1'b0;
        start_wr  = 1'b0;
        store_hit = 1'b0;
        fill      = 1'b0;
        case (state)
            IDLE: begin
                bus.rdata = data_mem[req_idx];
                if (bus.flush) begin
                    bus.stall = 1'b1;
                    state_nx  = FLUSH;
                end else if (bus.req_valid) begin
                    if (bus.req_we) begin
                        bus.stall = 1'b1;
                        start_wr  = 1'b1;
                        store_hit = hit;
                        state_nx  = WR_THRU;
                    end else if (!hit) begin
                        bus.stall = 1'b1;
                        start_rd  = 1'b1;
                        state_nx  = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                bus.stall = 1'b1;
                if (bus.mem_ack) begin
                    fill     = 1'b1;
                    state_nx = DONE;
                end
            end
            WR_THRU: begin
                bus.stall = 1'b1;
                if (bus.mem_ack) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            FLUSH: begin
                bus.stall = 1'b1;
                if (flush_cnt == '1) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            valid            <= '0;
            flush_cnt        <= '0;
            rdata_q          <= '0;
            bus.mem_req      <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.mem_size     <= 2'b00;
            bus.mem_byte_off <= 2'b00;
        end else begin
            state <= state_nx;
            if (start_rd || start_wr) begin
                bus.mem_req      <= 1'b1;
                bus.mem_we       <= start_wr;
                bus.mem_addr     <= {bus.req_addr[DATA_WIDTH-1:2], 2'b00};
                bus.mem_wdata    <= lane_data;
                bus.mem_size     <= bus.req_size;
                bus.mem_byte_off <= bus.req_addr[1:0];
            end else if ((state == RD_MISS || state == WR_THRU) && bus.mem_ack) begin
                bus.mem_req <= 1'b0;
                bus.mem_we  <= 1'b0;
            end
            if (fill) begin
                valid[fill_idx] <= 1'b1;
                rdata_q         <= bus.mem_rdata;
            end
            if (state == FLUSH) begin
                valid[flush_cnt] <= 1'b0;
                flush_cnt        <= flush_cnt + 1'b1;
            end else begin
                flush_cnt <= '0;
            end
        end
    end

    // Data and tags are deliberately left unreset; only the valid bits matter.
    always_ff @(posedge clk) begin
        if (!rst && store_hit) data_mem[req_idx] <= merged;
        if (!rst && fill) begin
            data_mem[fill_idx] <= bus.mem_rdata;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end
endmodule
